// File: rtl/blk_pkg.sv
// -----------------------------------------------------------------------------
// blk_pkg
// Shared definitions for the block-geometry timing generator:
//   - default block grid (HBLKS_DEF x VBLKS_DEF blocks of HP_DEF x VP_DEF px)
//   - RGB pixel width
//   - timing FSM state encoding
//   - cnt_w(): counter width helper that never returns zero
// -----------------------------------------------------------------------------
package blk_pkg;

  localparam int unsigned HBLKS_DEF = 10;
  localparam int unsigned VBLKS_DEF = 10;
  localparam int unsigned HP_DEF    = 30;
  localparam int unsigned VP_DEF    = 30;
  localparam int unsigned PIX_W     = 24;  // {R[23:16], G[15:8], B[7:0]}

  typedef enum logic {
    WAIT_VS = 1'b0,  // no frame start seen yet: video is passed through, not framed
    ACTIVE  = 1'b1   // inside a frame: counters run, strobes are generated
  } state_e;

  // Width of a counter that spans 0..n-1; a modulus of 1 still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blk_mod_cnt.sv
// -----------------------------------------------------------------------------
// blk_mod_cnt
// Modulo-N up counter with synchronous clear and a combinational wrap pulse.
// Clear has priority over enable.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   clr_i   in   synchronous clear to 0
//   en_i    in   count enable
//   cnt_o   out  current count, 0..N-1
//   wrap_o  out  high when enabled at N-1 (the count returns to 0 next cycle)
// -----------------------------------------------------------------------------
module blk_mod_cnt #(
  parameter int unsigned N = 2,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  assign wrap_o = en_i && (cnt_o == W'(N - 1));

  // NOTE: reset is synchronous here, so it lives inside the clocked branch and
  // is not in the sensitivity list; sequential state is written with <= only.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= wrap_o ? '0 : cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/blk_timing.sv
// -----------------------------------------------------------------------------
// blk_timing
// Block-geometry timing generator feeding the per-block luminance buffer.
// Turns raw vs/de/pixel video into block coordinates, per-block horizontal save
// strobes and per-block-row vertical save strobes, with every output registered
// exactly one cycle after its input. Frames whose geometry disagrees with the
// configured HBLKS x VBLKS grid of HP x VP pixel blocks raise a sticky error.
//
// Ports:
//   clk_i       in   pixel clock
//   rst_i       in   synchronous active-high reset
//   vs_i        in   vertical sync, rising edge starts a frame
//   de_i        in   data enable, one active pixel per cycle
//   wd_i        in   24-bit RGB pixel
//   ht_o        out  horizontal block index of the current de_o pixel
//   vt_o        out  vertical block index of the current de_o pixel
//   h_save_o    out  pulse with the last pixel of each horizontal block
//   v_save_o    out  pulse once per completed block row, after its last pixel
//   de_o        out  de_i delayed one cycle, held low until a frame starts
//   vs_o        out  vs_i delayed one cycle
//   wd_o        out  wd_i delayed one cycle
//   meas_w_o    out  (BLK_TIMING_STATS_EN) previous frame's longest line, pixels
//   meas_h_o    out  (BLK_TIMING_STATS_EN) previous frame's de line count
//   geom_err_o  out  sticky geometry error for the current frame
//
// Build option: define BLK_TIMING_STATS_EN to add the meas_w_o/meas_h_o frame
// measurement outputs.
// -----------------------------------------------------------------------------
module blk_timing
  import blk_pkg::*;
#(
  parameter int unsigned HBLKS = HBLKS_DEF,
  parameter int unsigned VBLKS = VBLKS_DEF,
  parameter int unsigned HP    = HP_DEF,
  parameter int unsigned VP    = VP_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     vs_i,
  input  logic                     de_i,
  input  logic [PIX_W-1:0]         wd_i,
  output logic [$clog2(HBLKS)-1:0] ht_o,
  output logic [$clog2(VBLKS)-1:0] vt_o,
  output logic                     h_save_o,
  output logic                     v_save_o,
  output logic                     de_o,
  output logic                     vs_o,
  output logic [PIX_W-1:0]         wd_o,
`ifdef BLK_TIMING_STATS_EN
  output logic [15:0]              meas_w_o,
  output logic [15:0]              meas_h_o,
`endif
  output logic                     geom_err_o
);

  localparam int unsigned HW = $clog2(HBLKS);
  localparam int unsigned VW = $clog2(VBLKS);
  localparam int unsigned PW = cnt_w(HP);
  localparam int unsigned LW = cnt_w(VP);

  state_e state_q, state_d;

  logic vs_rise;       // frame start; vs_o doubles as the previous vs_i sample
  logic pix_en;        // an accepted active pixel this cycle
  logic line_end;      // first blank cycle after an accepted line
  logic line_done_q;   // the full HBLKS*HP pixels of this line have been seen
  logic frame_done_q;  // the full VBLKS*VP lines of this frame have been seen

  logic [PW-1:0] px_cnt;
  logic [HW-1:0] ht_cnt;
  logic [LW-1:0] ln_cnt;
  logic [VW-1:0] vt_cnt;
  logic          px_wrap, ht_wrap, ln_wrap, vt_wrap;

  assign vs_rise = vs_i && !vs_o;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pix_en   = 1'b0;
    line_end = 1'b0;
    if (vs_rise) begin
      state_d = ACTIVE;
    end else if (state_q == ACTIVE) begin
      pix_en   = de_i;
      // de_o is the accepted de of the previous cycle, so this fires only for
      // lines that were actually counted in this frame.
      line_end = de_o && !de_i;
    end
  end

  // Pixel within block; stops once the line has its full width so overflow
  // pixels produce no h_save_o.
  blk_mod_cnt #(.N(HP), .W(PW)) u_px_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise || line_end),
    .en_i  (pix_en && !line_done_q),
    .cnt_o (px_cnt),
    .wrap_o(px_wrap)
  );

  // Horizontal block within line.
  blk_mod_cnt #(.N(HBLKS), .W(HW)) u_ht_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise || line_end),
    .en_i  (px_wrap),
    .cnt_o (ht_cnt),
    .wrap_o(ht_wrap)
  );

  // Line within block row; stops once the frame has its full height so extra
  // lines produce no v_save_o.
  blk_mod_cnt #(.N(VP), .W(LW)) u_ln_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise),
    .en_i  (line_end && !frame_done_q),
    .cnt_o (ln_cnt),
    .wrap_o(ln_wrap)
  );

  // Block row within frame.
  blk_mod_cnt #(.N(VBLKS), .W(VW)) u_vt_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (vs_rise),
    .en_i  (ln_wrap),
    .cnt_o (vt_cnt),
    .wrap_o(vt_wrap)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the pixel data path is reset as well because every output,
      // wd_o included, must read 0 straight out of reset.
      state_q      <= WAIT_VS;
      vs_o         <= 1'b0;
      wd_o         <= '0;
      de_o         <= 1'b0;
      h_save_o     <= 1'b0;
      v_save_o     <= 1'b0;
      ht_o         <= '0;
      vt_o         <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      geom_err_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_o     <= vs_i;
      wd_o     <= wd_i;
      de_o     <= pix_en;
      h_save_o <= px_wrap;
      // ln_wrap is only ever raised on a blank cycle, so v_save_o cannot
      // coincide with h_save_o and lands right after the line's last pixel.
      v_save_o <= ln_wrap;
      ht_o     <= line_done_q  ? HW'(HBLKS - 1) : ht_cnt;
      vt_o     <= frame_done_q ? VW'(VBLKS - 1) : vt_cnt;

      if (vs_rise || line_end) begin
        line_done_q <= 1'b0;
      end else if (ht_wrap) begin
        line_done_q <= 1'b1;
      end

      if (vs_rise) begin
        frame_done_q <= 1'b0;
      end else if (vt_wrap) begin
        frame_done_q <= 1'b1;
      end

      // Short line, pixel past the grid width, or line past the grid height.
      if (vs_rise) begin
        geom_err_o <= 1'b0;
      end else if ((line_end && !line_done_q) ||
                   (pix_en && (line_done_q || frame_done_q))) begin
        geom_err_o <= 1'b1;
      end
    end
  end

`ifdef BLK_TIMING_STATS_EN
  // Raw frame measurements, independent of the configured grid and FSM state.
  logic        de_raw_q;
  logic [15:0] len_q;    // pixels so far in the current line
  logic [15:0] max_q;    // longest completed line this frame
  logic [15:0] lines_q;  // completed de lines this frame
  logic        raw_end;

  assign raw_end = de_raw_q && !de_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_raw_q <= 1'b0;
      len_q    <= '0;
      max_q    <= '0;
      lines_q  <= '0;
      meas_w_o <= '0;
      meas_h_o <= '0;
    end else begin
      de_raw_q <= de_i;
      len_q    <= de_i ? len_q + 16'd1 : '0;
      if (vs_rise) begin
        meas_w_o <= max_q;
        meas_h_o <= lines_q;
        max_q    <= '0;
        lines_q  <= '0;
      end else if (raw_end) begin
        if (len_q > max_q) begin
          max_q <= len_q;
        end
        lines_q <= lines_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_blk_timing.sv
// -----------------------------------------------------------------------------
// tb_blk_timing
// Directed bench for blk_timing on a 4x3 grid of 2x2-pixel blocks. Each step
// drives one cycle of vs/de/pixel input and queues the outputs that cycle must
// produce; one cycle later the queued entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_blk_timing;

  localparam int HB = 4;
  localparam int VB = 3;
  localparam int HP = 2;
  localparam int VP = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        vs_i  = 1'b0;
  logic        de_i  = 1'b0;
  logic [23:0] wd_i  = '0;
  logic [1:0]  ht_o;
  logic [1:0]  vt_o;
  logic        h_save_o, v_save_o, de_o, vs_o, geom_err_o;
  logic [23:0] wd_o;
`ifdef BLK_TIMING_STATS_EN
  logic [15:0] meas_w_o, meas_h_o;
`endif

  blk_timing #(.HBLKS(HB), .VBLKS(VB), .HP(HP), .VP(VP)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .vs_i      (vs_i),
    .de_i      (de_i),
    .wd_i      (wd_i),
    .ht_o      (ht_o),
    .vt_o      (vt_o),
    .h_save_o  (h_save_o),
    .v_save_o  (v_save_o),
    .de_o      (de_o),
    .vs_o      (vs_o),
    .wd_o      (wd_o),
`ifdef BLK_TIMING_STATS_EN
    .meas_w_o  (meas_w_o),
    .meas_h_o  (meas_h_o),
`endif
    .geom_err_o(geom_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        de;
    logic [1:0]  ht;
    logic [1:0]  vt;
    logic        hs;
    logic        vsv;
    logic        vs;
    logic [23:0] wd;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string ctx    = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", ctx, tag, obs, expv);
    end
  endtask

  // One input cycle: drive, queue the expected outputs, clock, compare.
  task automatic step(input logic vs, input logic de, input logic rst, input exp_t e);
    exp_t x;
    vs_i  = vs;
    de_i  = de;
    rst_i = rst;
    wd_i  = 24'($urandom);
    e.vs  = rst ? 1'b0  : vs;
    e.wd  = rst ? 24'h0 : wd_i;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    x = exp_q.pop_front();
    check("de_o",       32'(de_o),       32'(x.de));
    check("h_save_o",   32'(h_save_o),   32'(x.hs));
    check("v_save_o",   32'(v_save_o),   32'(x.vsv));
    check("vs_o",       32'(vs_o),       32'(x.vs));
    check("wd_o",       32'(wd_o),       32'(x.wd));
    check("geom_err_o", 32'(geom_err_o), 32'(x.err));
    if (x.de) begin
      check("ht_o", 32'(ht_o), 32'(x.ht));
      check("vt_o", 32'(vt_o), 32'(x.vt));
    end
  endtask

  function automatic exp_t idle(input logic err);
    exp_t e = '{default: '0};
    e.err = err;
    return e;
  endfunction

  // n-pixel line followed by two blank cycles. act=0 means the DUT is still
  // waiting for a frame. extra marks a line past the grid height.
  task automatic line(input int n, input int vt_e, input bit act, input bit vsave_e,
                      input bit err_in, input bit err_out, input bit extra);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e     = idle(act && (err_in || extra || i >= HB * HP));
      e.de  = act;
      e.ht  = (i / HP >= HB) ? 2'(HB - 1) : 2'(i / HP);
      e.vt  = 2'(vt_e);
      e.hs  = act && (i % HP == HP - 1) && (i < HB * HP);
      step(1'b0, 1'b1, 1'b0, e);
    end
    e     = idle(err_out);
    e.vsv = vsave_e;
    step(1'b0, 1'b0, 1'b0, e);
    step(1'b0, 1'b0, 1'b0, idle(err_out));
  endtask

  // Two cycles of vs high, one low; the rising edge clears the sticky error.
  task automatic vs_pulse();
    step(1'b1, 1'b0, 1'b0, idle(1'b0));
    step(1'b1, 1'b0, 1'b0, idle(1'b0));
    step(1'b0, 1'b0, 1'b0, idle(1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    #1;
    // Reset with de and pixel data toggling: every output must read 0.
    ctx = "reset";
    step(1'b0, 1'b1, 1'b1, idle(1'b0));
    step(1'b0, 1'b1, 1'b1, idle(1'b0));
    step(1'b0, 1'b0, 1'b0, idle(1'b0));

    // No frame start yet: de_o and strobes stay low, data passes through.
    ctx = "wait_vs";
    line(8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame A: two full lines complete row 0, then a 10-pixel line in row 1.
    ctx = "frame_a_vs";
    vs_pulse();
    ctx = "frame_a_l1";
    line(8, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ctx = "frame_a_l2";
    line(8, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ctx = "frame_a_long";
    line(10, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Frame B: short line flags the error; following full line restarts ht at 0;
    // vs after three lines drops the partial row silently and clears the error.
    ctx = "frame_b_vs";
    vs_pulse();
    ctx = "frame_b_l1";
    line(8, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ctx = "frame_b_short";
    line(6, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    ctx = "frame_b_l3";
    line(8, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    ctx = "frame_b_restart";
    vs_pulse();

    // Frame C: full 6-line frame, then two lines past the grid height.
    for (int l = 0; l < VB * VP; l++) begin
      ctx = $sformatf("frame_c_l%0d", l + 1);
      line(8, l / VP, 1'b1, (l % VP) == VP - 1, 1'b0, 1'b0, 1'b0);
    end
    ctx = "frame_c_extra1";
    line(8, VB - 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    ctx = "frame_c_extra2";
    line(8, VB - 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset mid-line: rest of the line is ignored until the next frame start.
    ctx = "midline_vs";
    vs_pulse();
    ctx = "midline_pre";
    for (int i = 0; i < 3; i++) begin
      e    = idle(1'b0);
      e.de = 1'b1;
      e.ht = 2'(i / HP);
      e.hs = (i % HP) == HP - 1;
      step(1'b0, 1'b1, 1'b0, e);
    end
    ctx = "midline_rst";
    step(1'b0, 1'b1, 1'b1, idle(1'b0));
    ctx = "midline_post";
    line(5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
